// File: rtl/button_defs.sv
// Shared definitions for the button gesture logic: FSM encoding and 50 MHz timing defaults.
package button_defs;

   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      PRESSED        = 3'd1,
      LONG_HELD      = 3'd2,
      WAIT_SECOND    = 3'd3,
      SECOND_PRESSED = 3'd4
   } state_t;

   localparam int unsigned DEF_LONG_CYCLES = 50_000_000;  // 1 s at 50 MHz
   localparam int unsigned DEF_GAP_CYCLES  = 12_500_000;  // 250 ms at 50 MHz
   localparam int unsigned DEF_CNT_WIDTH   = 26;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pin-level inputs.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into short / long / double-click pulses plus a long-hold level.
module button_press_classifier
   import button_defs::*;
#(
   parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic button_in,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic long_held
);

   localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_WIDTH;

   generate
      if (CNT_LIMIT <= 64'(max_u(LONG_CYCLES, GAP_CYCLES)) || LONG_CYCLES < 2 || GAP_CYCLES < 2)
      begin : g_bad_params
         $error("button_press_classifier: CNT_WIDTH too small or LONG/GAP_CYCLES below 2");
      end
   endgenerate

   // The state that sees the first level change consumes that cycle, so the counter
   // reads N-1 on the N-th cycle of a run; the decision is taken when it reads N-2.
   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 2);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 2);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic                 btn_s;
   state_t               state_reg, state_next;
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic                 short_reg, short_next;
   logic                 long_reg, long_next;
   logic                 double_reg, double_next;
   logic                 held_reg, held_next;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (button_in),
      .q     (btn_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         short_reg  <= 1'b0;
         long_reg   <= 1'b0;
         double_reg <= 1'b0;
         held_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         short_reg  <= short_next;
         long_reg   <= long_next;
         double_reg <= double_next;
         held_reg   <= held_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:           if (btn_s) state_next = PRESSED;
         PRESSED: begin
            if (!btn_s)                    state_next = WAIT_SECOND;
            else if (cnt_reg == LONG_LAST) state_next = LONG_HELD;
         end
         LONG_HELD:      if (!btn_s) state_next = IDLE;
         WAIT_SECOND: begin
            if (btn_s)                    state_next = SECOND_PRESSED;
            else if (cnt_reg == GAP_LAST) state_next = IDLE;
         end
         SECOND_PRESSED: begin
            if (!btn_s)                    state_next = IDLE;
            else if (cnt_reg == LONG_LAST) state_next = LONG_HELD;
         end
         default:        state_next = IDLE;
      endcase

      cnt_next = cnt_reg;
      if (state_next != state_reg)
         cnt_next = '0;
      else if ((state_reg == PRESSED || state_reg == WAIT_SECOND || state_reg == SECOND_PRESSED)
               && cnt_reg != CNT_MAX)
         cnt_next = cnt_reg + 1'b1;
   end

   always_comb begin
      short_next  = (state_reg == WAIT_SECOND) && (state_next == IDLE);
      long_next   = (state_reg == PRESSED) && (state_next == LONG_HELD);
      double_next = (state_reg == SECOND_PRESSED) && (state_next != SECOND_PRESSED);
      // A long second press also lands in LONG_HELD but must not raise the hold flag.
      held_next   = held_reg;
      if (long_next)
         held_next = 1'b1;
      else if (state_next != LONG_HELD)
         held_next = 1'b0;
   end

   assign short_press  = short_reg;
   assign long_press   = long_reg;
   assign double_click = double_reg;
   assign long_held    = held_reg;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: run-length gesture model plus directed literal checks.
module tb_button_press_classifier;

   localparam int L    = 20;
   localparam int G    = 10;
   localparam int MAXC = 10200;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic button_in = 1'b0;
   logic short_press, long_press, double_click, long_held;

   button_press_classifier #(
      .LONG_CYCLES (L),
      .GAP_CYCLES  (G),
      .CNT_WIDTH   (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .button_in    (button_in),
      .short_press  (short_press),
      .long_press   (long_press),
      .double_click (double_click),
      .long_held    (long_held)
   );

   always #5 clk = ~clk;

   bit       bin [MAXC];       // button_in driven during cycle c
   bit       bs  [MAXC];       // expected synchronised level
   bit [3:0] exp_out [MAXC];   // {short, long, double, held}
   int       seg_len;
   int       n_cmp = 0;
   int       n_bad = 0;
   int       cyc = 0;
   bit       checking = 1'b0;

   int       first_short, first_long, first_double;
   int       num_short, num_long, num_double, num_held;
   logic [3:0] act_v;

   function automatic int find_level(input int start, input bit val, input int n);
      for (int k = start; k < n; k++)
         if (bs[k] == val) return k;
      return n;
   endfunction

   task automatic mark(input int idx, input int pos, input int n);
      if (idx < n) exp_out[idx][pos] = 1'b1;
   endtask

   // Expected outputs from run lengths of the synchronised level.
   task automatic build_model(input int n);
      int c, t0, t1, t2, t3;
      for (int k = 0; k < n; k++) begin
         bs[k]      = (k >= 2) ? bin[k-2] : 1'b0;
         exp_out[k] = 4'b0000;
      end
      c = 0;
      while (c < n) begin
         t0 = find_level(c, 1'b1, n);
         if (t0 >= n) break;
         t1 = find_level(t0, 1'b0, n);
         if (t1 - t0 >= L) begin
            mark(t0 + L, 2, n);
            for (int k = t0 + L; k <= t1 && k < n; k++) exp_out[k][0] = 1'b1;
            c = t1;
            continue;
         end
         t2 = find_level(t1, 1'b1, n);
         if (t2 - t1 >= G) begin
            mark(t1 + G, 3, n);
            c = t2;
            continue;
         end
         t3 = find_level(t2, 1'b0, n);
         if (t3 - t2 >= L) mark(t2 + L, 1, n);
         else              mark(t3 + 1, 1, n);
         c = t3;
      end
   endtask

   task automatic seg_clear();
      seg_len = 0;
   endtask

   task automatic seg_add(input bit val, input int len);
      for (int k = 0; k < len && seg_len < MAXC; k++) begin
         bin[seg_len] = val;
         seg_len++;
      end
   endtask

   task automatic run_seq();
      build_model(seg_len);
      reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      cyc       = 0;
      button_in = bin[0];
      checking  = 1'b1;
      for (int c = 1; c < seg_len; c++) begin
         @(posedge clk);
         #1;
         cyc       = c;
         button_in = bin[c];
      end
      @(negedge clk);
      #1;
      checking = 1'b0;
   endtask

   task automatic check_int(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         if (cyc == 0) begin
            first_short = -1; first_long = -1; first_double = -1;
            num_short = 0; num_long = 0; num_double = 0; num_held = 0;
         end
         act_v = {short_press, long_press, double_click, long_held};
         n_cmp++;
         if (act_v !== exp_out[cyc]) begin
            n_bad++;
            $display("FAIL outputs cycle %0d: got %b, expected %b", cyc, act_v, exp_out[cyc]);
         end
         n_cmp++;
         if ($countones(act_v[3:1]) > 1) begin
            n_bad++;
            $display("FAIL exclusive cycle %0d: got %b, expected at most one pulse", cyc, act_v[3:1]);
         end
         if (act_v[3]) begin if (first_short  < 0) first_short  = cyc; num_short++;  end
         if (act_v[2]) begin if (first_long   < 0) first_long   = cyc; num_long++;   end
         if (act_v[1]) begin if (first_double < 0) first_double = cyc; num_double++; end
         if (act_v[0]) num_held++;
      end
   end

   initial begin
      // short press
      seg_clear(); seg_add(0, 3); seg_add(1, 5); seg_add(0, 32); run_seq();
      check_int("short_time", first_short, 20);
      check_int("short_count", num_short, 1);
      check_int("short_no_long", num_long, 0);
      check_int("short_no_double", num_double, 0);
      $display("short press: short at %0d", first_short);

      // long press
      seg_clear(); seg_add(0, 3); seg_add(1, 30); seg_add(0, 15); run_seq();
      check_int("long_time", first_long, 25);
      check_int("long_held_len", num_held, 11);
      check_int("long_no_short", num_short, 0);
      $display("long press: long at %0d held %0d", first_long, num_held);

      // double click
      seg_clear(); seg_add(0, 3); seg_add(1, 4); seg_add(0, 3); seg_add(1, 4); seg_add(0, 30); run_seq();
      check_int("double_time", first_double, 17);
      check_int("double_no_short", num_short, 0);
      check_int("double_count", num_double, 1);
      $display("double click: double at %0d", first_double);

      // press of LONG-1 cycles
      seg_clear(); seg_add(0, 3); seg_add(1, 19); seg_add(0, 25); run_seq();
      check_int("p19_short_time", first_short, 34);
      check_int("p19_no_long", num_long, 0);
      $display("press 19: short at %0d", first_short);

      // press of LONG cycles
      seg_clear(); seg_add(0, 3); seg_add(1, 20); seg_add(0, 15); run_seq();
      check_int("p20_long_time", first_long, 25);
      check_int("p20_held_len", num_held, 1);
      check_int("p20_no_short", num_short, 0);
      $display("press 20: long at %0d", first_long);

      // second press at gap GAP-1
      seg_clear(); seg_add(0, 3); seg_add(1, 4); seg_add(0, 9); seg_add(1, 3); seg_add(0, 20); run_seq();
      check_int("gap9_double_time", first_double, 22);
      check_int("gap9_no_short", num_short, 0);
      $display("gap 9: double at %0d", first_double);

      // second press at gap GAP
      seg_clear(); seg_add(0, 3); seg_add(1, 4); seg_add(0, 10); seg_add(1, 3); seg_add(0, 25); run_seq();
      check_int("gap10_short_time", first_short, 19);
      check_int("gap10_short_count", num_short, 2);
      check_int("gap10_no_double", num_double, 0);
      $display("gap 10: first short at %0d, shorts %0d", first_short, num_short);

      // reset during PRESSED at cnt=12
      seg_clear(); seg_add(0, 3); seg_add(1, 16); run_seq();
      #1 reset = 1'b0;
      #1 check_int("rst_pressed_outputs", {short_press, long_press, double_click, long_held}, 0);
      $display("reset in pressed: outputs %b", {short_press, long_press, double_click, long_held});

      // reset while long_held is high
      seg_clear(); seg_add(0, 3); seg_add(1, 26); run_seq();
      check_int("pre_rst_held_len", num_held, 4);
      #1 reset = 1'b0;
      #1 check_int("rst_held_clear", int'(long_held), 0);
      $display("reset in long hold: long_held %b", long_held);

      // button held across reset release
      button_in = 1'b1;
      seg_clear(); seg_add(1, 30); seg_add(0, 15); run_seq();
      check_int("held_reset_long_time", first_long, 22);
      check_int("held_reset_held_len", num_held, 11);
      $display("held across reset: long at %0d", first_long);

      // random gestures
      seg_clear(); seg_add(0, 3);
      while (seg_len < 10000) begin
         seg_add(1, int'($urandom_range(1, 26)));
         seg_add(0, int'($urandom_range(1, 14)));
      end
      seg_add(0, 40);
      run_seq();
      $display("random: %0d cycles, short %0d long %0d double %0d", seg_len, num_short, num_long, num_double);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Sits directly downstream of the button debouncer and consumes its `debouncedButton` level.
- Classifies each user gesture into one of three single-cycle event pulses: short press, long press or double click.
- Also provides a level flag while a long press is being held.
- Feeds menu/control logic that needs discrete events rather than a raw level.

Parameters:
- LONG_CYCLES, 50_000_000: consecutive held cycles that qualify a long press (1 s at 50 MHz). Must be >= 2.
- GAP_CYCLES, 12_500_000: maximum released cycles between first release and second press for a double click (250 ms). Must be >= 2.
- CNT_WIDTH, 26: counter width. Must satisfy 2^CNT_WIDTH > max(LONG_CYCLES, GAP_CYCLES). An elaboration-time check fails the build otherwise.

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset, input, 1: asynchronous, active-low reset.
- button_in, input, 1: debounced button level, active high. Treated as asynchronous because it is combinationally derived from the raw pin.
- short_press, output, 1: one-cycle pulse; single press released before LONG_CYCLES, with no second press within GAP_CYCLES.
- long_press, output, 1: one-cycle pulse when a first press reaches LONG_CYCLES.
- double_click, output, 1: one-cycle pulse on a qualifying second press.
- long_held, output, 1: level, high from the long_press pulse cycle until the release is seen.

Behaviour:
- Reset is asynchronous and active-low: reset=0 immediately forces state IDLE, counter 0, sync flops 0 and all outputs 0.
- Input synchronisation:
  - 2-flop synchroniser; btn_s = button_in delayed by 2 clk edges.
  - All timing below is in cycles of btn_s. T0 = first cycle btn_s=1; T1 = first cycle btn_s=0 after a press.
- Single counter cnt: cleared on every state transition, +1 per cycle in counting states, saturates (never wraps).
- All outputs are registered. A decision made in cycle X is visible in cycle X+1.
- FSM states:
  - IDLE: btn_s=1 -> PRESSED (cnt=0).
  - PRESSED: cnt counts held cycles.
    - cnt reaches LONG_CYCLES-1 with btn_s=1 -> LONG_HELD; long_press pulses at T0+LONG_CYCLES and long_held sets at the same cycle.
    - btn_s=0 earlier -> WAIT_SECOND (cnt=0).
  - LONG_HELD: btn_s=0 -> IDLE; long_held clears at the next cycle. No short_press is ever emitted for a long press.
  - WAIT_SECOND: cnt counts released cycles.
    - btn_s=1 before cnt reaches GAP_CYCLES-1 -> SECOND_PRESSED.
    - cnt reaches GAP_CYCLES-1 with btn_s=0 -> IDLE; short_press pulses at T1+GAP_CYCLES.
  - SECOND_PRESSED: btn_s=0 at cycle T3 -> IDLE; double_click pulses at T3+1.
    - Held to LONG_CYCLES: emit double_click (not long_press), then -> LONG_HELD with long_held=0.
- Boundaries:
  - Press lasting exactly LONG_CYCLES-1 cycles is short.
  - Press lasting exactly LONG_CYCLES cycles is long.
  - Second press at exactly T1+GAP_CYCLES-1 counts as a double click.
  - Second press at T1+GAP_CYCLES gives a short_press plus a new PRESSED sequence.
- Mutual exclusion: at most one of short_press, long_press, double_click is high in any cycle.
- Reset mid-gesture: the gesture is discarded with no pulse. A button held across reset release is seen as a new rising edge 2 cycles later and starts a fresh PRESSED.
- button_in glitches shorter than one clock may be missed. The upstream debouncer guarantees stable levels.

Decomposition:
- Shared include/package `button_defs`:
  - FSM state encodings (IDLE=0, PRESSED=1, LONG_HELD=2, WAIT_SECOND=3, SECOND_PRESSED=4; 3 bits).
  - Default timing constants for 50 MHz.
- One sub-module, `sync_2ff`: generic 2-flop synchroniser with asynchronous active-low reset, reused for other pin inputs.

Test Plan:
- Bench parameters: LONG_CYCLES=20, GAP_CYCLES=10.
- Short press: hold 5 cycles, release, idle 15 -> one short_press exactly 10 cycles after btn_s falls; long_press and double_click stay 0.
- Long press: hold 30 cycles -> long_press 1 cycle at T0+20; long_held high from T0+20 until 1 cycle after btn_s falls; no short_press.
- Double click: press 4, release 3, press 4, release -> double_click 1 cycle after the second btn_s fall; no short_press, even after waiting 20 more cycles.
- Boundary:
  - Press of 19 cycles -> short.
  - Press of 20 cycles -> long.
  - Second press starting at gap 9 -> double_click.
  - Second press starting at gap 10 -> short_press, then the second press is classified independently.
- Reset: assert reset=0 during PRESSED at cnt=12 -> all outputs 0 immediately. Release reset with button_in held high -> a long_press pulse arrives 20 cycles after the new btn_s rise.
- Random gestures for 10k cycles against a reference model -> pulse types and cycle times match; never more than one pulse per cycle.
